// File: rtl/light_sequencer_if.sv
// Button inputs and selector-control outputs of the light sequencer.
// master drives the buttons (board side); slave is the sequencer itself.
interface light_sequencer_if;
    logic       mode_btn;
    logic       step_btn;
    logic       sel;
    logic       step;
    logic [1:0] mode;
    logic [7:0] step_count;

    modport master (output mode_btn, step_btn, input sel, step, mode, step_count);
    modport slave  (input mode_btn, step_btn, output sel, step, mode, step_count);
endinterface

// File: rtl/light_sequencer.sv
// Drives the lights selector: mode FSM, manual/auto step arbitration with a
// holdoff gap that spaces step pulses to cover converter latency.
module light_sequencer #(
    parameter int DWELL_CYCLES = 100,
    parameter int BLINK_CYCLES = 50,
    parameter int GAP_CYCLES   = 4
) (
    input logic               clk,
    input logic               rst,
    light_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_WHITE  = 2'd0,
        ST_MANUAL = 2'd1,
        ST_AUTO   = 2'd2,
        ST_BLINK  = 2'd3
    } state_t;

    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam int HW = $clog2(GAP_CYCLES + 1);

    state_t        r_state, w_state_next;
    logic          r_mode_prev, r_step_prev;
    logic          r_sel, w_sel_next;
    logic          r_step;
    logic [7:0]    r_count;
    logic [DW-1:0] r_dwell, w_dwell_next;
    logic [BW-1:0] r_blink, w_blink_next;
    logic [HW-1:0] r_hold, w_hold_next;
    logic          r_pend, w_pend_next;
    logic          w_fire;

    logic w_mode_edge, w_step_edge, w_man_req, w_auto_req, w_req;

    assign w_mode_edge = bus.mode_btn & ~r_mode_prev;
    assign w_step_edge = bus.step_btn & ~r_step_prev;
    // A mode change in the same cycle swallows the step edge.
    assign w_man_req   = w_step_edge & ~w_mode_edge & (r_state != ST_WHITE);
    assign w_auto_req  = (r_state == ST_AUTO) && (r_dwell == DW'(DWELL_CYCLES - 1));
    assign w_req       = w_man_req | w_auto_req;

    always_comb begin
        w_state_next = r_state;
        w_fire       = 1'b0;
        w_pend_next  = r_pend;
        w_hold_next  = (r_hold != '0) ? r_hold - 1'b1 : '0;
        w_dwell_next = '0;
        w_blink_next = '0;
        w_sel_next   = 1'b1;

        if (w_mode_edge) begin
            case (r_state)
                ST_WHITE:  w_state_next = ST_MANUAL;
                ST_MANUAL: w_state_next = ST_AUTO;
                ST_AUTO:   w_state_next = ST_BLINK;
                default:   w_state_next = ST_WHITE;
            endcase
        end

        // Holdoff counts the blocked cycles after the pulse cycle, so a
        // load of GAP_CYCLES-1 puts consecutive pulses GAP_CYCLES apart.
        if (w_state_next == ST_WHITE) begin
            w_pend_next = 1'b0;
            w_hold_next = '0;
        end else if ((w_req || r_pend) && (r_hold == '0)) begin
            w_fire      = 1'b1;
            w_pend_next = 1'b0;
            w_hold_next = HW'(GAP_CYCLES - 1);
        end else if (w_req) begin
            w_pend_next = 1'b1;
        end

        if ((r_state == ST_AUTO) && (w_state_next == ST_AUTO) && !w_fire)
            w_dwell_next = r_dwell + 1'b1;

        case (w_state_next)
            ST_WHITE: w_sel_next = 1'b0;
            ST_BLINK: begin
                if (r_state != ST_BLINK) begin
                    w_sel_next = 1'b1;
                end else if (r_blink == BW'(BLINK_CYCLES - 1)) begin
                    w_sel_next = ~r_sel;
                end else begin
                    w_sel_next   = r_sel;
                    w_blink_next = r_blink + 1'b1;
                end
            end
            default: w_sel_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_WHITE;
            r_mode_prev <= 1'b1;
            r_step_prev <= 1'b1;
            r_sel       <= 1'b0;
            r_step      <= 1'b0;
            r_count     <= '0;
            r_dwell     <= '0;
            r_blink     <= '0;
            r_hold      <= '0;
            r_pend      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_mode_prev <= bus.mode_btn;
            r_step_prev <= bus.step_btn;
            r_sel       <= w_sel_next;
            r_step      <= w_fire;
            r_count     <= r_count + {7'd0, w_fire};
            r_dwell     <= w_dwell_next;
            r_blink     <= w_blink_next;
            r_hold      <= w_hold_next;
            r_pend      <= w_pend_next;
        end
    end

    assign bus.sel        = r_sel;
    assign bus.step       = r_step;
    assign bus.mode       = r_state;
    assign bus.step_count = r_count;
endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with default parameters
// (DWELL 100, BLINK 50, GAP 4); step pulses are logged by cycle number.
module tb_light_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   pulse_q[$];
    int   p0, e, b;

    light_sequencer_if bus ();

    light_sequencer #(.DWELL_CYCLES(100), .BLINK_CYCLES(50), .GAP_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.step === 1'b1) pulse_q.push_back(cyc);

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_mode();
        bus.mode_btn = 1'b1;
        tick();
        bus.mode_btn = 1'b0;
    endtask

    initial begin
        bus.mode_btn = 1'b0;
        bus.step_btn = 1'b0;
        ticks(3);
        rst = 1'b0;
        tick();
        check_eq("rst_mode", bus.mode, 0);
        check_eq("rst_sel", bus.sel, 0);
        check_eq("rst_step", bus.step, 0);
        check_eq("rst_count", bus.step_count, 0);

        // WHITE -> MANUAL, single step
        press_mode();
        check_eq("manual_mode", bus.mode, 1);
        check_eq("manual_sel", bus.sel, 1);
        bus.step_btn = 1'b1;
        tick();
        bus.step_btn = 1'b0;
        check_eq("single_step_hi", bus.step, 1);
        tick();
        check_eq("single_step_lo", bus.step, 0);
        check_eq("single_count", bus.step_count, 1);
        ticks(6);

        // Edges at q, q+2, q+4: pulses only at q+1 and q+5
        pulse_q.delete();
        bus.step_btn = 1'b1; tick(); p0 = cyc;
        bus.step_btn = 1'b0; tick();
        bus.step_btn = 1'b1; tick();
        bus.step_btn = 1'b0; tick();
        bus.step_btn = 1'b1; tick();
        bus.step_btn = 1'b0;
        check_eq("gap_pulse2_now", bus.step, 1);
        ticks(8);
        check_eq("gap_npulses", pulse_q.size(), 2);
        if (pulse_q.size() == 2) begin
            check_eq("gap_first", pulse_q[0], p0);
            check_eq("gap_spacing", pulse_q[1] - pulse_q[0], 4);
        end
        check_eq("gap_count", bus.step_count, 3);

        // Same-cycle mode and step edges: mode wins
        pulse_q.delete();
        bus.mode_btn = 1'b1;
        bus.step_btn = 1'b1;
        tick();
        bus.mode_btn = 1'b0;
        bus.step_btn = 1'b0;
        e = cyc;
        check_eq("tie_mode", bus.mode, 2);
        check_eq("tie_step", bus.step, 0);

        // AUTO, no buttons for 350 cycles after entry
        while (cyc < e + 350) tick();
        check_eq("auto_npulses", pulse_q.size(), 3);
        if (pulse_q.size() == 3) begin
            check_eq("auto_p1", pulse_q[0] - e, 100);
            check_eq("auto_p2", pulse_q[1] - e, 200);
            check_eq("auto_p3", pulse_q[2] - e, 300);
        end
        check_eq("auto_count", bus.step_count, 6);

        // Step edge sampled together with the dwell expiry
        while (cyc < e + 399) tick();
        bus.step_btn = 1'b1;
        tick();
        bus.step_btn = 1'b0;
        while (cyc < e + 510) tick();
        check_eq("merge_npulses", pulse_q.size(), 5);
        if (pulse_q.size() == 5) begin
            check_eq("merge_p4", pulse_q[3] - e, 400);
            check_eq("merge_p5", pulse_q[4] - e, 500);
        end
        check_eq("merge_count", bus.step_count, 8);

        // BLINK phases
        press_mode();
        b = cyc;
        check_eq("blink_mode", bus.mode, 3);
        while (cyc < b + 25) tick();
        check_eq("blink_ph0", bus.sel, 1);
        while (cyc < b + 49) tick();
        check_eq("blink_ph0_end", bus.sel, 1);
        tick();
        check_eq("blink_ph1_start", bus.sel, 0);
        while (cyc < b + 125) tick();
        check_eq("blink_ph2", bus.sel, 1);
        while (cyc < b + 175) tick();
        check_eq("blink_ph3", bus.sel, 0);
        while (cyc < b + 200) tick();

        // Back to WHITE; steps ignored
        press_mode();
        check_eq("white_mode", bus.mode, 0);
        check_eq("white_sel", bus.sel, 0);
        pulse_q.delete();
        bus.step_btn = 1'b1;
        tick();
        bus.step_btn = 1'b0;
        ticks(6);
        check_eq("white_npulses", pulse_q.size(), 0);
        check_eq("white_count", bus.step_count, 8);

        // Reset with pending set and holdoff busy
        press_mode();
        bus.step_btn = 1'b1; tick();
        bus.step_btn = 1'b0; tick();
        bus.step_btn = 1'b1; tick();
        bus.step_btn = 1'b0;
        pulse_q.delete();
        rst = 1'b1;
        tick();
        check_eq("mrst_mode", bus.mode, 0);
        check_eq("mrst_sel", bus.sel, 0);
        check_eq("mrst_step", bus.step, 0);
        check_eq("mrst_count", bus.step_count, 0);
        rst = 1'b0;
        ticks(10);
        check_eq("mrst_no_late", pulse_q.size(), 0);
        check_eq("mrst_count_after", bus.step_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
